// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fft_pkg
//  Brief    : Shared sizing and sequencer state encoding for the 64-point FFT
//  Revision : 1.0  initial release
// ============================================================================
package fft_pkg;

  localparam int N_LOG2   = 6;
  localparam int N_POINTS = 2 ** N_LOG2;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    PROC  = 3'd2,
    DRAIN = 3'd3,
    OUT   = 3'd4
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/fft_iter_counter.sv
`default_nettype none
// ============================================================================
//  Module   : fft_iter_counter
//  Brief    : Butterfly/level counter; level advances when the iteration wraps
//  Revision : 1.0  initial release
// ============================================================================
module fft_iter_counter #(
  parameter int N_LOG2 = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [N_LOG2-1:0] butterfly_iter,
  output logic [N_LOG2-1:0] fft_level,
  output logic              last_iter,
  output logic              last_level
);

  localparam logic [N_LOG2-1:0] c_one        = N_LOG2'(1);
  localparam logic [N_LOG2-1:0] c_last_iter  = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [N_LOG2-1:0] c_last_level = N_LOG2'(N_LOG2 - 1);

  logic [N_LOG2-1:0] r_iter;
  logic [N_LOG2-1:0] r_level;

  // The final level wraps straight back to 0 so the level never reads N_LOG2.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      r_iter  <= '0;
      r_level <= '0;
    end else if (enable) begin
      if (last_iter) begin
        r_iter  <= '0;
        r_level <= last_level ? '0 : r_level + c_one;
      end else begin
        r_iter  <= r_iter + c_one;
      end
    end
  end

  assign butterfly_iter = r_iter;
  assign fft_level      = r_level;
  assign last_iter      = (r_iter == c_last_iter);
  assign last_level     = (r_level == c_last_level);

endmodule
`default_nettype wire

// File: rtl/fft_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : fft_sequencer
//  Brief    : Frame control FSM for the radix-2 FFT (load, levels, unload).
//             Define FFT_LEVEL_DRAIN_EN to insert DRAIN_CYCLES idle cycles
//             between butterfly levels.
//  Revision : 1.0  initial release
// ============================================================================
module fft_sequencer #(
  parameter int N_LOG2       = fft_pkg::N_LOG2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              out_valid,
  output logic              out_last,
  output logic              load,
  output logic              processing,
  output logic              done,
  output logic [N_LOG2-1:0] fft_level,
  output logic [N_LOG2-1:0] butterfly_iter,
  output logic [N_LOG2-1:0] load_address,
  output logic [N_LOG2-1:0] out_address,
  output logic              we_0,
  output logic              we_1,
  output logic              rd_sel
);
  import fft_pkg::*;

  localparam logic [2:0] c_st_idle  = IDLE;
  localparam logic [2:0] c_st_load  = LOAD;
  localparam logic [2:0] c_st_proc  = PROC;
  localparam logic [2:0] c_st_drain = DRAIN;
  localparam logic [2:0] c_st_out   = OUT;

  localparam int                c_points    = (N_LOG2 == fft_pkg::N_LOG2) ? N_POINTS : (1 << N_LOG2);
  localparam logic [N_LOG2-1:0] c_last_addr = N_LOG2'(c_points - 1);
  localparam logic [N_LOG2-1:0] c_one       = N_LOG2'(1);

  logic [2:0]        r_state;
  logic [2:0]        w_state_nxt;
  logic [N_LOG2-1:0] r_load_address;
  logic [N_LOG2-1:0] r_out_address;
  logic [N_LOG2-1:0] w_iter;
  logic [N_LOG2-1:0] w_level;
  logic              w_last_iter;
  logic              w_last_level;
  logic              w_drain_done;
  logic              w_in_load;
  logic              w_in_proc;
  logic              w_in_drain;
  logic              w_in_out;

  assign w_in_load  = (r_state == c_st_load);
  assign w_in_proc  = (r_state == c_st_proc);
  assign w_in_drain = (r_state == c_st_drain);
  assign w_in_out   = (r_state == c_st_out);

  fft_iter_counter #(
    .N_LOG2 (N_LOG2)
  ) u_iter_counter (
    .clk            (clk),
    .reset          (reset),
    .clear          (!(w_in_proc || w_in_drain)),
    .enable         (w_in_proc),
    .butterfly_iter (w_iter),
    .fft_level      (w_level),
    .last_iter      (w_last_iter),
    .last_level     (w_last_level)
  );

`ifdef FFT_LEVEL_DRAIN_EN
  localparam int             c_dw         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [c_dw-1:0] c_drain_last = c_dw'(DRAIN_CYCLES - 1);
  localparam logic [c_dw-1:0] c_drain_one  = c_dw'(1);

  logic [c_dw-1:0] r_drain_cnt;

  always_ff @(posedge clk) begin
    if (reset || !w_in_drain) begin
      r_drain_cnt <= '0;
    end else begin
      r_drain_cnt <= r_drain_cnt + c_drain_one;
    end
  end

  assign w_drain_done = (r_drain_cnt == c_drain_last);
`else
  logic w_unused_drain;
  assign w_unused_drain = (DRAIN_CYCLES != 0);
  assign w_drain_done   = 1'b1;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_load;
      c_st_load:  if (in_valid && (r_load_address == c_last_addr)) w_state_nxt = c_st_proc;
      c_st_proc: begin
        if (w_last_iter) begin
          if (w_last_level) begin
            w_state_nxt = c_st_out;
          end else begin
`ifdef FFT_LEVEL_DRAIN_EN
            w_state_nxt = c_st_drain;
`else
            w_state_nxt = c_st_proc;
`endif
          end
        end
      end
      c_st_drain: if (w_drain_done) w_state_nxt = c_st_proc;
      c_st_out:   if (out_ready && (r_out_address == c_last_addr)) w_state_nxt = c_st_idle;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Addresses are held at 0 outside their own phase, so they start clean every frame.
  always_ff @(posedge clk) begin
    if (reset || !w_in_load) begin
      r_load_address <= '0;
    end else if (in_valid) begin
      r_load_address <= r_load_address + c_one;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || !w_in_out) begin
      r_out_address <= '0;
    end else if (out_ready) begin
      r_out_address <= r_out_address + c_one;
    end
  end

  assign load           = w_in_load;
  assign in_ready       = w_in_load;
  assign processing     = w_in_proc || w_in_drain;
  assign done           = w_in_out;
  assign out_valid      = w_in_out;
  assign out_last       = w_in_out && (r_out_address == c_last_addr);
  assign fft_level      = w_level;
  assign butterfly_iter = w_iter;
  assign load_address   = r_load_address;
  assign out_address    = r_out_address;
  assign rd_sel         = w_in_proc && w_level[0];

  // Write strobes are suppressed while reset is asserted so a partial frame leaves the RAMs alone.
  assign we_0 = !reset && ((w_in_load && in_valid) || (w_in_proc && w_level[0]));
  assign we_1 = !reset && w_in_proc && !w_level[0];

endmodule
`default_nettype wire

// File: tb/tb_fft_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_sequencer
//  Brief    : Randomized self-checking bench for fft_sequencer
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_sequencer;

`ifdef FFT_LEVEL_DRAIN_EN
  localparam int DRAIN = 2;
`else
  localparam int DRAIN = 0;
`endif
  localparam int SEG        = 32 + DRAIN;
  localparam int PROC_TOTAL = 192 + 5 * DRAIN;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       out_valid;
  logic       out_last;
  logic       load;
  logic       processing;
  logic       done;
  logic [5:0] fft_level;
  logic [5:0] butterfly_iter;
  logic [5:0] load_address;
  logic [5:0] out_address;
  logic       we_0;
  logic       we_1;
  logic       rd_sel;

  int n_checks = 0;
  int n_errors = 0;

  fft_sequencer #(
    .N_LOG2       (6),
    .DRAIN_CYCLES (2)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_ready      (out_ready),
    .out_valid      (out_valid),
    .out_last       (out_last),
    .load           (load),
    .processing     (processing),
    .done           (done),
    .fft_level      (fft_level),
    .butterfly_iter (butterfly_iter),
    .load_address   (load_address),
    .out_address    (out_address),
    .we_0           (we_0),
    .we_1           (we_1),
    .rd_sel         (rd_sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_flags"}, 32'({load, processing, done, in_ready, out_valid, out_last, we_0, we_1, rd_sel}), 32'd0);
    check({tag, "_ctrs"}, 32'({fft_level, butterfly_iter, load_address, out_address}), 32'd0);
  endtask

  // One frame; abort_k >= 0 asserts reset at that PROC cycle index and ends the frame there.
  task automatic run_frame(input int gap_mode, input int ready_mode, input int abort_k);
    int   accepted;
    int   cyc;
    int   hs;
    int   lvl;
    int   off;
    int   exp_lvl;
    int   exp_iter;
    logic v;

    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b0; #1;
    check("start_cycle_we", 32'({we_0, we_1, in_ready}), 32'd0);

    accepted = 0; cyc = 0;
    while (accepted < 64 && cyc < 1000) begin
      @(negedge clk);
      case (gap_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      in_valid = v; start = 1'($urandom_range(0, 1)); out_ready = 1'($urandom_range(0, 1)); #1;
      check("load_flags", 32'({load, in_ready, processing, done}), 32'b1100);
      check("load_address", 32'(load_address), accepted);
      check("load_we", 32'({we_0, we_1}), 32'({v, 1'b0}));
      if (v) accepted++;
      cyc++;
    end
    if (accepted < 64) check("load_timeout", accepted, 64);

    for (int k = 0; k < PROC_TOTAL; k++) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1)); #1;
      lvl = k / SEG; off = k % SEG;
      if (off < 32) begin
        exp_lvl = lvl; exp_iter = off;
      end else begin
        exp_lvl = lvl + 1; exp_iter = 0;
      end
      check("proc_flags", 32'({load, processing, done, in_ready, out_valid}), 32'b01000);
      check("proc_level", 32'(fft_level), exp_lvl);
      check("proc_iter", 32'(butterfly_iter), exp_iter);
      if (off < 32) check("proc_we_rd", 32'({we_0, we_1, rd_sel}), 32'({exp_lvl[0], ~exp_lvl[0], exp_lvl[0]}));
      else          check("drain_we", 32'({we_0, we_1}), 32'd0);
      if (k == abort_k) begin
        reset = 1'b1; in_valid = 1'b1; #1;
        check("reset_cycle_we", 32'({we_0, we_1}), 32'd0);
        @(negedge clk);
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
        check_idle("after_proc_reset");
        return;
      end
    end

    hs = 0; cyc = 0;
    while (hs < 64 && cyc < 1000) begin
      @(negedge clk);
      case (ready_mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      out_ready = v; in_valid = 1'($urandom_range(0, 1)); start = 1'($urandom_range(0, 1)); #1;
      check("out_flags", 32'({load, processing, done, out_valid, in_ready}), 32'b00110);
      check("out_address", 32'(out_address), hs);
      check("out_last", 32'(out_last), 32'(hs == 63));
      check("out_we_rd", 32'({we_0, we_1, rd_sel}), 32'd0);
      check("out_ctrs", 32'({fft_level, butterfly_iter}), 32'd0);
      if (v) hs++;
      cyc++;
    end
    if (hs < 64) check("out_timeout", hs, 64);

    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0; #1;
    check_idle("post_frame");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle("reset");
    reset = 1'b0;

    // Samples offered in IDLE without start must not be written.
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; #1;
      check_idle("idle_in_valid");
    end

    run_frame(0, 0, -1);
    run_frame(1, 1, -1);
    run_frame(2, 2, 3 * SEG + 10);
    run_frame(2, 2, -1);

    // Reset in LOAD while a sample is offered.
    @(negedge clk);
    start = 1'b1; in_valid = 1'b0; #1;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; #1;
    check("reset_load_pre_we", 32'(we_0), 32'd1);
    @(negedge clk);
    reset = 1'b1; #1;
    check("reset_load_we", 32'({we_0, we_1}), 32'd0);
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; #1;
    check_idle("after_load_reset");

    run_frame(2, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
